// File: rtl/algo_2ror1w_a2_pkg.sv
// Shared types for the 2ror1w_a2 client-side scheduler: issue kinds and request entries.
package algo_2ror1w_a2_pkg;
  localparam int READ_LAT_DEF = 2;
  localparam int WIDTH_DEF    = 32;
  localparam int BITADDR_DEF  = 13;

  typedef enum logic [1:0] {ISS_IDLE, ISS_READ, ISS_WRITE, ISS_STARVE} issue_e;

  typedef struct packed {
    logic [BITADDR_DEF-1:0] adr;
  } rd_req_t;

  typedef struct packed {
    logic [BITADDR_DEF-1:0] adr;
    logic [WIDTH_DEF-1:0]   dat;
  } wr_req_t;
endpackage

// File: rtl/algo_2ror1w_a2_client_sched_if.sv
// Macro-side client port of the 2ror1w_a2 memory: scheduler is master, macro is slave.
interface algo_2ror1w_a2_client_sched_if #(
  parameter int WIDTH   = 32,
  parameter int BITADDR = 13
);
  logic                 ready;
  logic                 write;
  logic [BITADDR-1:0]   wr_adr;
  logic [WIDTH-1:0]     din;
  logic [1:0]           read;
  logic [2*BITADDR-1:0] rd_adr;
  logic [1:0]           rd_vld;
  logic [2*WIDTH-1:0]   rd_dout;

  modport master (input ready, rd_vld, rd_dout, output write, wr_adr, din, read, rd_adr);
  modport slave  (output ready, rd_vld, rd_dout, input write, wr_adr, din, read, rd_adr);
endinterface

// File: rtl/algo_2ror1w_a2_req_fifo.sv
// Synchronous request FIFO; pointers carry an extra wrap bit to separate full from empty.
module algo_2ror1w_a2_req_fifo #(
  parameter int W     = 13,
  parameter int DEPTH = 4,
  parameter int BITD  = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);
  typedef logic [BITD:0] ptr_t;

  logic [W-1:0] mem [DEPTH];
  ptr_t         wptr, rptr;
  logic         do_push, do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[BITD] != rptr[BITD]) && (wptr[BITD-1:0] == rptr[BITD-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rptr[BITD-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + ptr_t'(1);
      if (do_pop)  rptr <= rptr + ptr_t'(1);
    end
  end

  always_ff @(posedge clk)
    if (do_push) mem[wptr[BITD-1:0]] <= din;
endmodule

// File: rtl/algo_2ror1w_a2_client_sched.sv
// Buffers two read streams and one write stream, issuing reads-first with a write
// starvation bound, and tracks outstanding reads per port for protocol errors.
module algo_2ror1w_a2_client_sched
  import algo_2ror1w_a2_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int BITADDR    = 13,
  parameter int FIFO_DEPTH = 4,
  parameter int BITFIFO    = 2,
  parameter int WR_STARV   = 8,
  parameter int READ_LAT   = READ_LAT_DEF,
  parameter int BITOUT     = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           rq_vld,
  output logic [1:0]           rq_rdy,
  input  logic [2*BITADDR-1:0] rq_adr,
  input  logic                 wq_vld,
  output logic                 wq_rdy,
  input  logic [BITADDR-1:0]   wq_adr,
  input  logic [WIDTH-1:0]     wq_din,
  algo_2ror1w_a2_client_sched_if.master mem,
  output logic [1:0]           rsp_vld,
  output logic [2*WIDTH-1:0]   rsp_dout,
  output logic                 err
);
  localparam int SW = $clog2(WR_STARV + 1);
  localparam logic [BITOUT-1:0] OUT_MAX = '1;

  if ((1 << BITOUT) <= READ_LAT + 1) begin : g_bitout_chk
    $error("BITOUT too narrow for READ_LAT outstanding reads");
  end

  typedef struct packed {
    logic [BITADDR-1:0] adr;
    logic [WIDTH-1:0]   dat;
  } wr_ent_t;

  logic [1:0]               rq_full, rq_empty, rd_pop;
  logic [1:0][BITADDR-1:0]  rq_head;
  logic                     wq_full, wq_empty, wr_pop;
  wr_ent_t                  wq_in, wq_head;
  issue_e                   kind;
  logic [SW-1:0]            starv_cnt;
  logic [1:0][BITOUT-1:0]   out_cnt;

  logic                     write_q;
  logic [BITADDR-1:0]       wr_adr_q;
  logic [WIDTH-1:0]         din_q;
  logic [1:0]               read_q;
  logic [1:0][BITADDR-1:0]  rd_adr_q;

  for (genvar p = 0; p < 2; p++) begin : g_rq
    algo_2ror1w_a2_req_fifo #(.W(BITADDR), .DEPTH(FIFO_DEPTH), .BITD(BITFIFO)) u_rq (
      .clk  (clk),
      .rst  (rst),
      .push (rq_vld[p] && rq_rdy[p]),
      .din  (rq_adr[p*BITADDR +: BITADDR]),
      .pop  (rd_pop[p]),
      .full (rq_full[p]),
      .empty(rq_empty[p]),
      .head (rq_head[p])
    );
  end

  assign wq_in = '{adr: wq_adr, dat: wq_din};

  algo_2ror1w_a2_req_fifo #(.W(BITADDR + WIDTH), .DEPTH(FIFO_DEPTH), .BITD(BITFIFO)) u_wq (
    .clk  (clk),
    .rst  (rst),
    .push (wq_vld && wq_rdy),
    .din  (wq_in),
    .pop  (wr_pop),
    .full (wq_full),
    .empty(wq_empty),
    .head (wq_head)
  );

  assign rq_rdy = ~rq_full;
  assign wq_rdy = ~wq_full;

  // Priority: forced write, then any reads, then an unforced write.
  always_comb begin
    kind = ISS_IDLE;
    if (mem.ready) begin
      if (!wq_empty && starv_cnt >= SW'(WR_STARV)) kind = ISS_STARVE;
      else if (rq_empty != 2'b11)                  kind = ISS_READ;
      else if (!wq_empty)                          kind = ISS_WRITE;
    end
  end

  assign rd_pop = (kind == ISS_READ) ? ~rq_empty : 2'b00;
  assign wr_pop = (kind == ISS_STARVE) || (kind == ISS_WRITE);

  always_ff @(posedge clk) begin
    if (rst) begin
      starv_cnt <= '0;
    end else if (mem.ready) begin
      if (wr_pop || wq_empty)
        starv_cnt <= '0;
      else if (kind == ISS_READ && starv_cnt < SW'(WR_STARV))
        starv_cnt <= starv_cnt + SW'(1);
    end
  end

  // Address/data registers only move with their strobe so the pins hold last value.
  always_ff @(posedge clk) begin
    if (rst) begin
      write_q  <= 1'b0;
      wr_adr_q <= '0;
      din_q    <= '0;
      read_q   <= 2'b00;
      rd_adr_q <= '0;
    end else begin
      write_q <= wr_pop;
      read_q  <= rd_pop;
      if (wr_pop) begin
        wr_adr_q <= wq_head.adr;
        din_q    <= wq_head.dat;
      end
      for (int p = 0; p < 2; p++)
        if (rd_pop[p]) rd_adr_q[p] <= rq_head[p];
    end
  end

  assign mem.write  = write_q;
  assign mem.wr_adr = wr_adr_q;
  assign mem.din    = din_q;
  assign mem.read   = read_q;
  assign mem.rd_adr = rd_adr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_cnt <= '0;
      err     <= 1'b0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        case ({read_q[p], mem.rd_vld[p]})
          2'b10: if (out_cnt[p] == OUT_MAX) err <= 1'b1;
                 else out_cnt[p] <= out_cnt[p] + BITOUT'(1);
          2'b01: if (out_cnt[p] == '0) err <= 1'b1;
                 else out_cnt[p] <= out_cnt[p] - BITOUT'(1);
          default: ;
        endcase
      end
    end
  end

  assign rsp_vld  = mem.rd_vld;
  assign rsp_dout = mem.rd_dout;
endmodule

// File: tb/tb_algo_2ror1w_a2_client_sched.sv
// Bench for the 2ror1w_a2 client scheduler: vector table, scoreboard and a latency-2 macro model.
module tb_algo_2ror1w_a2_client_sched;
  localparam int W = 32;
  localparam int A = 13;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [1:0]       rq_vld, rq_rdy;
  logic [2*A-1:0]   rq_adr;
  logic             wq_vld, wq_rdy;
  logic [A-1:0]     wq_adr;
  logic [W-1:0]     wq_din;
  logic [1:0]       rsp_vld;
  logic [2*W-1:0]   rsp_dout;
  logic             err;
  logic             ready_drv;
  logic [1:0]       model_vld, inj_vld;
  logic [2*W-1:0]   model_dat;

  algo_2ror1w_a2_client_sched_if #(.WIDTH(W), .BITADDR(A)) mem_if ();
  assign mem_if.ready   = ready_drv;
  assign mem_if.rd_vld  = model_vld | inj_vld;
  assign mem_if.rd_dout = model_dat;

  algo_2ror1w_a2_client_sched dut (
    .clk(clk), .rst(rst),
    .rq_vld(rq_vld), .rq_rdy(rq_rdy), .rq_adr(rq_adr),
    .wq_vld(wq_vld), .wq_rdy(wq_rdy), .wq_adr(wq_adr), .wq_din(wq_din),
    .mem(mem_if),
    .rsp_vld(rsp_vld), .rsp_dout(rsp_dout), .err(err)
  );

  int errors = 0;
  int checks = 0;

  logic [A-1:0]   exp_rd  [2][$];
  logic [A+W-1:0] exp_wr  [$];
  logic [W-1:0]   exp_rsp [2][$];

  logic [1:0] pin_rd;
  logic       pin_wr;

  function automatic logic [W-1:0] fdat(int p, logic [A-1:0] a);
    return 32'hA000_0000 | (32'(p) << 20) | 32'(a);
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic fail(string name);
    checks++;
    errors++;
    $display("FAIL %s: got event expected none", name);
  endtask

  // Inputs change on the falling edge; accepted pushes are scored immediately.
  task automatic drive(logic [1:0] v, logic [A-1:0] a0, logic [A-1:0] a1,
                       logic wv, logic [A-1:0] wa, logic [W-1:0] wd);
    @(negedge clk);
    rq_vld = v;  rq_adr = {a1, a0};
    wq_vld = wv; wq_adr = wa; wq_din = wd;
    if (v[0] && rq_rdy[0]) exp_rd[0].push_back(a0);
    if (v[1] && rq_rdy[1]) exp_rd[1].push_back(a1);
    if (wv && wq_rdy)      exp_wr.push_back({wa, wd});
  endtask

  task automatic idle();
    drive(2'b00, '0, '0, 1'b0, '0, '0);
  endtask

  task automatic sample();
    #2;
    pin_rd = mem_if.read;
    pin_wr = mem_if.write;
  endtask

  task automatic drain(int n);
    for (int i = 0; i < n; i++) idle();
  endtask

  // Macro model (read latency 2) plus scoreboard checks of every issued strobe and response.
  logic [1:0]     vh0, vh1;
  logic [2*W-1:0] dh0, dh1;
  initial begin
    vh0 = '0; vh1 = '0; dh0 = '0; dh1 = '0;
    model_vld = '0; model_dat = '0;
    forever begin
      @(negedge clk);
      model_vld = vh1; model_dat = dh1;
      vh1 = vh0; dh1 = dh0;
      for (int p = 0; p < 2; p++) begin
        vh0[p] = (mem_if.read[p] === 1'b1);
        dh0[p*W +: W] = fdat(p, mem_if.rd_adr[p*A +: A]);
      end
      #1;
      for (int p = 0; p < 2; p++) begin
        if (mem_if.read[p] === 1'b1) begin
          exp_rsp[p].push_back(fdat(p, mem_if.rd_adr[p*A +: A]));
          if (exp_rd[p].size() == 0) fail("rd_unexpected");
          else chk("rd_adr", 64'(mem_if.rd_adr[p*A +: A]), 64'(exp_rd[p].pop_front()));
        end
      end
      if (mem_if.write === 1'b1) begin
        if (exp_wr.size() == 0) fail("wr_unexpected");
        else chk("wr_adr_din", 64'({mem_if.wr_adr, mem_if.din}), 64'(exp_wr.pop_front()));
        if (mem_if.read !== 2'b00) fail("rd_with_wr");
      end
      for (int p = 0; p < 2; p++) begin
        if (mem_if.rd_vld[p] === 1'b1) begin
          chk("rsp_vld", 64'(rsp_vld[p]), 64'd1);
          if (model_vld[p]) begin
            if (exp_rsp[p].size() == 0) fail("rsp_unexpected");
            else chk("rsp_dout", 64'(rsp_dout[p*W +: W]), 64'(exp_rsp[p].pop_front()));
          end
        end
      end
    end
  end

  typedef struct {
    logic [1:0]   v;
    logic [A-1:0] a0, a1;
    logic         wv;
    logic [A-1:0] wa;
    logic [W-1:0] wd;
    logic [1:0]   exp_read;
    logic         exp_write;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int n, first, last;
    bit found;

    tbl[0] = '{2'b01, 13'h0010, 13'h0000, 1'b0, 13'h0000, 32'h0,          2'b01, 1'b0};
    tbl[1] = '{2'b10, 13'h0000, 13'h01AB, 1'b0, 13'h0000, 32'h0,          2'b10, 1'b0};
    tbl[2] = '{2'b11, 13'h0000, 13'h1FFF, 1'b0, 13'h0000, 32'h0,          2'b11, 1'b0};
    tbl[3] = '{2'b00, 13'h0000, 13'h0000, 1'b1, 13'h0123, 32'hDEADBEEF,   2'b00, 1'b1};
    tbl[4] = '{2'b01, 13'h0055, 13'h0000, 1'b1, 13'h1FFF, 32'h0000_0000,  2'b01, 1'b0};
    tbl[5] = '{2'b11, 13'h0A0A, 13'h0505, 1'b1, 13'h0777, 32'hFFFF_FFFF,  2'b11, 1'b0};

    rst = 1'b1; ready_drv = 1'b1; inj_vld = '0;
    rq_vld = '0; rq_adr = '0; wq_vld = 1'b0; wq_adr = '0; wq_din = '0;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_write",  64'(mem_if.write),  64'd0);
    chk("rst_read",   64'(mem_if.read),   64'd0);
    chk("rst_rd_adr", 64'(mem_if.rd_adr), 64'd0);
    chk("rst_err",    64'(err),           64'd0);
    chk("rst_rsp",    64'(rsp_vld),       64'd0);
    chk("rst_rq_rdy", 64'(rq_rdy),        64'd3);
    chk("rst_wq_rdy", 64'(wq_rdy),        64'd1);
    @(negedge clk); rst = 1'b0;

    // Isolated transactions: pins two cycles after accept.
    for (int i = 0; i < 6; i++) begin
      drive(tbl[i].v, tbl[i].a0, tbl[i].a1, tbl[i].wv, tbl[i].wa, tbl[i].wd);
      idle();
      @(negedge clk);
      sample();
      chk("vec_read",  64'(pin_rd), 64'(tbl[i].exp_read));
      chk("vec_write", 64'(pin_wr), 64'(tbl[i].exp_write));
      drain(6);
    end

    // Write starvation under continuous reads on both ports.
    drive(2'b11, 13'h0200, 13'h0300, 1'b1, 13'h1FFF, 32'h5A5A_0001);
    sample();
    n = 0; found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      drive(2'b11, 13'(13'h0201 + i), 13'(13'h0301 + i), 1'b0, '0, '0);
      sample();
      if (pin_wr) begin
        found = 1;
        chk("starv_read_cycles", 64'(n), 64'd8);
        chk("starv_read_low",    64'(pin_rd), 64'd0);
      end else if (pin_rd != 2'b00) n++;
    end
    if (!found) fail("starv_timeout");
    else begin
      drive(2'b11, 13'h0280, 13'h0380, 1'b0, '0, '0);
      sample();
      chk("starv_reads_resume", 64'(pin_rd), 64'd3);
    end
    drain(10);

    // Ready low: port 1 fills after four pushes, then drains on consecutive cycles.
    @(negedge clk); ready_drv = 1'b0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (i < 5) begin
        drive(2'b10, '0, 13'(13'h0100 + i), 1'b0, '0, '0);
        chk("rq_rdy1_fill", 64'(rq_rdy[1]), 64'(i < 4));
      end else idle();
      sample();
      if (pin_rd != 2'b00 || pin_wr) n++;
    end
    chk("no_issue_not_ready", 64'(n), 64'd0);
    @(negedge clk); ready_drv = 1'b1;
    n = 0; first = -1; last = -1;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      sample();
      if (pin_rd[1]) begin
        if (first < 0) first = j;
        last = j;
        n++;
      end
    end
    chk("ready_drain_cnt",    64'(n), 64'd4);
    chk("ready_drain_consec", 64'(last - first), 64'd3);
    drain(6);

    // Writes only: three back-to-back pulses.
    n = 0; first = -1; last = -1;
    for (int j = 0; j < 9; j++) begin
      if (j < 3) drive(2'b00, '0, '0, 1'b1, 13'(13'h1000 + j), 32'h1234_0000 + 32'(j));
      else idle();
      sample();
      if (pin_wr) begin
        if (first < 0) first = j;
        last = j;
        n++;
      end
    end
    chk("wr_only_cnt",    64'(n), 64'd3);
    chk("wr_only_consec", 64'(last - first), 64'd2);
    drain(4);
    chk("err_clean", 64'(err), 64'd0);

    // Spurious return on port 1.
    @(negedge clk); inj_vld = 2'b10;
    @(negedge clk); inj_vld = 2'b00;
    #2;
    chk("err_set", 64'(err), 64'd1);
    drain(5);
    chk("err_sticky", 64'(err), 64'd1);

    // Reset with read and write FIFOs half full.
    @(negedge clk); ready_drv = 1'b0;
    drive(2'b01, 13'h00AA, '0, 1'b1, 13'h0AAA, 32'hCAFE_0001);
    drive(2'b01, 13'h00AB, '0, 1'b1, 13'h0AAB, 32'hCAFE_0002);
    @(negedge clk);
    rst = 1'b1; rq_vld = '0; wq_vld = 1'b0;
    exp_rd[0].delete(); exp_rd[1].delete(); exp_wr.delete();
    exp_rsp[0].delete(); exp_rsp[1].delete();
    @(negedge clk);
    rst = 1'b0; ready_drv = 1'b1;
    #2;
    chk("mid_rst_write",  64'(mem_if.write),  64'd0);
    chk("mid_rst_read",   64'(mem_if.read),   64'd0);
    chk("mid_rst_wr_adr", 64'(mem_if.wr_adr), 64'd0);
    chk("mid_rst_din",    64'(mem_if.din),    64'd0);
    chk("mid_rst_rd_adr", 64'(mem_if.rd_adr), 64'd0);
    chk("mid_rst_err",    64'(err),           64'd0);
    chk("mid_rst_rq_rdy", 64'(rq_rdy),        64'd3);
    chk("mid_rst_wq_rdy", 64'(wq_rdy),        64'd1);
    n = 0;
    for (int j = 0; j < 8; j++) begin
      idle();
      sample();
      if (pin_rd != 2'b00 || pin_wr) n++;
    end
    chk("no_stale_issue", 64'(n), 64'd0);

    drain(4);
    chk("sb_rd0_empty",  64'(exp_rd[0].size()),  64'd0);
    chk("sb_rd1_empty",  64'(exp_rd[1].size()),  64'd0);
    chk("sb_wr_empty",   64'(exp_wr.size()),     64'd0);
    chk("sb_rsp0_empty", 64'(exp_rsp[0].size()), 64'd0);
    chk("sb_rsp1_empty", 64'(exp_rsp[1].size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
